// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over one
// shared memory port and drives the datapath enables, mux selects and ALUOp.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       instr_retired,
    output logic       illegal,
    output logic       timeout_err
);

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int              CW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;
    logic          illegal_r;
    logic          timeout_r;
    logic          set_ill_s;
    logic          set_to_s;
    logic          req_expired_s;

    logic is_r_s, is_i_s, is_l_s, is_s_s, is_beq_s, is_bne_s;
    logic is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, legal_s;

    // Instruction class decode; funct3 is qualified so that a class flag implies legality
    always_comb begin
        is_r_s     = (opcode == OP_R);
        is_i_s     = (opcode == OP_I);
        is_l_s     = (opcode == OP_L) && (funct3 == 3'b010);
        is_s_s     = (opcode == OP_S) && (funct3 == 3'b010);
        is_beq_s   = (opcode == OP_B) && (funct3 == 3'b000);
        is_bne_s   = (opcode == OP_B) && (funct3 == 3'b001);
        is_lui_s   = (opcode == OP_LUI);
        is_auipc_s = (opcode == OP_AUIPC);
        is_jal_s   = (opcode == OP_JAL);
        is_jalr_s  = (opcode == OP_JALR) && (funct3 == 3'b000);
        legal_s    = is_r_s | is_i_s | is_l_s | is_s_s | is_beq_s | is_bne_s |
                     is_lui_s | is_auipc_s | is_jal_s | is_jalr_s;
    end

    assign req_expired_s = !mem_ready && (wait_cnt_r == WAIT_LAST);

    // Next-state and control outputs (Mealy on mem_ready/zero so handshakes complete in-cycle)
    always_comb begin
        state_nxt_s   = state_r;
        set_ill_s     = 1'b0;
        set_to_s      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        mdr_we        = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 1'b0;
        alu_op        = 3'b000;
        instr_retired = 1'b0;

        if ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
            if (is_r_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b0; alu_op = 3'b000;
            end else if (is_i_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b1; alu_op = 3'b001;
            end else if (is_l_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b1; alu_op = 3'b010;
            end else if (is_s_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b1; alu_op = 3'b011;
            end else if (is_beq_s || is_bne_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b0; alu_op = 3'b100;
            end else if (is_lui_s) begin
                alu_src_a = 2'd2; alu_src_b = 1'b1; alu_op = 3'b101;
            end else if (is_auipc_s) begin
                alu_src_a = 2'd1; alu_src_b = 1'b1; alu_op = 3'b101;
            end else if (is_jalr_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b1; alu_op = 3'b101;
            end else if (is_jal_s) begin
                alu_src_a = 2'd0; alu_src_b = 1'b0; alu_op = 3'b101;
            end else begin
                alu_op = 3'b000;
            end
        end else begin
            alu_op = 3'b000;
        end

        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_we       = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else if (req_expired_s) begin
                    set_to_s    = 1'b1;
                    state_nxt_s = ST_TRAP;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (legal_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    set_ill_s   = 1'b1;
                    state_nxt_s = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (is_beq_s || is_bne_s) begin
                    pc_we         = 1'b1;
                    pc_src        = ((is_beq_s && zero) || (is_bne_s && !zero)) ? 2'd1 : 2'd0;
                    instr_retired = 1'b1;
                    state_nxt_s   = ST_FETCH;
                end else if (is_jal_s || is_jalr_s) begin
                    pc_we         = 1'b1;
                    pc_src        = is_jalr_s ? 2'd2 : 2'd1;
                    reg_write     = 1'b1;
                    wb_sel        = 2'd2;
                    instr_retired = 1'b1;
                    state_nxt_s   = ST_FETCH;
                end else if (is_l_s || is_s_s) begin
                    state_nxt_s = ST_MEM;
                end else if (is_r_s || is_i_s || is_lui_s || is_auipc_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            ST_MEM: begin
                mem_addr_sel = 1'b1;
                if (is_l_s) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        mdr_we      = 1'b1;
                        state_nxt_s = ST_WB;
                    end else if (req_expired_s) begin
                        set_to_s    = 1'b1;
                        state_nxt_s = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end else if (is_s_s) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_we         = 1'b1;
                        pc_src        = 2'd0;
                        instr_retired = 1'b1;
                        state_nxt_s   = ST_FETCH;
                    end else if (req_expired_s) begin
                        set_to_s    = 1'b1;
                        state_nxt_s = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write     = 1'b1;
                wb_sel        = is_l_s ? 2'd1 : 2'd0;
                pc_we         = 1'b1;
                pc_src        = 2'd0;
                instr_retired = 1'b1;
                state_nxt_s   = ST_FETCH;
            end
            ST_TRAP: begin
                state_nxt_s = ST_TRAP;
            end
            default: begin
                state_nxt_s = ST_TRAP;
            end
        endcase
    end

    // Wait counter counts unanswered request cycles; any other cycle leaves it at zero
    always_comb begin
        if (((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready && !req_expired_s) begin
            wait_cnt_nxt_s = wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_nxt_s = '0;
        end
    end

    // State, wait counter and sticky error flags
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= ST_BOOT;
            wait_cnt_r <= '0;
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            illegal_r  <= illegal_r | set_ill_s;
            timeout_r  <= timeout_r | set_to_s;
        end
    end

    assign state       = state_r;
    assign illegal     = illegal_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: each instruction is expanded from its class into a per-cycle trace of
// expected outputs, and a single compare process checks the DUT against it every cycle.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    localparam int K_R = 0, K_I = 1, K_L = 2, K_S = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9, K_BAD = 10;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, mem_addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0] pc_src, wb_sel, alu_src_a;
    logic       reg_write, alu_src_b, instr_retired, illegal, timeout_err;
    logic [2:0] alu_op, state;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .instr_retired(instr_retired), .illegal(illegal), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_read, mem_write, mem_addr_sel, ir_we, mdr_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       instr_retired, illegal, timeout_err;
    } outv_t;

    typedef struct {
        logic       rstn;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       rdy;
        outv_t      exp;
        string      tag;
    } step_t;

    step_t plan[$];
    int    errors = 0;
    int    checks = 0;
    bit    m_ill = 1'b0;
    bit    m_to = 1'b0;
    bit    chk_en = 1'b0;
    outv_t exp_cur;
    outv_t dut_v;
    string tag_cur = "";
    int    cyc = 0;

    always_comb begin
        dut_v.state = state; dut_v.mem_read = mem_read; dut_v.mem_write = mem_write;
        dut_v.mem_addr_sel = mem_addr_sel; dut_v.ir_we = ir_we; dut_v.mdr_we = mdr_we;
        dut_v.pc_we = pc_we; dut_v.pc_src = pc_src; dut_v.reg_write = reg_write;
        dut_v.wb_sel = wb_sel; dut_v.alu_src_a = alu_src_a; dut_v.alu_src_b = alu_src_b;
        dut_v.alu_op = alu_op; dut_v.instr_retired = instr_retired;
        dut_v.illegal = illegal; dut_v.timeout_err = timeout_err;
    end

    function automatic outv_t base(int st);
        outv_t v;
        v = '0;
        v.state = 3'(st);
        v.illegal = m_ill;
        v.timeout_err = m_to;
        return v;
    endfunction

    // ALU operand/op table per instruction class
    function automatic outv_t with_alu(outv_t vin, int k);
        outv_t v;
        v = vin;
        case (k)
            K_R:       begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b0; v.alu_op = 3'b000; end
            K_I:       begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b1; v.alu_op = 3'b001; end
            K_L:       begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b1; v.alu_op = 3'b010; end
            K_S:       begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b1; v.alu_op = 3'b011; end
            K_BEQ,
            K_BNE:     begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b0; v.alu_op = 3'b100; end
            K_LUI:     begin v.alu_src_a = 2'd2; v.alu_src_b = 1'b1; v.alu_op = 3'b101; end
            K_AUIPC:   begin v.alu_src_a = 2'd1; v.alu_src_b = 1'b1; v.alu_op = 3'b101; end
            K_JALR:    begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b1; v.alu_op = 3'b101; end
            K_JAL:     begin v.alu_src_a = 2'd0; v.alu_src_b = 1'b0; v.alu_op = 3'b101; end
            default:   begin v.alu_op = 3'b000; end
        endcase
        return v;
    endfunction

    task automatic push(input logic rstn, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic rdy, input outv_t e, input string tag);
        step_t s;
        s.rstn = rstn; s.op = op; s.f3 = f3; s.z = z; s.rdy = rdy; s.exp = e; s.tag = tag;
        plan.push_back(s);
    endtask

    task automatic plan_trap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            push(1'b1, 7'(i * 13), 3'(i), 1'(i % 2), 1'(i % 2), base(7), tag);
        end
    endtask

    task automatic plan_reset(input string tag);
        m_ill = 1'b0;
        m_to = 1'b0;
        push(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, base(0), tag);
        push(1'b1, 7'd0, 3'd0, 1'b0, 1'b1, base(0), tag);
    endtask

    // One instruction: fw / mw are the number of not-ready cycles before memory answers
    task automatic plan_instr(input int k, input logic [6:0] op, input logic [2:0] f3,
                              input logic z, input int fw, input int mw, input string tag);
        outv_t v;
        for (int i = 0; i < fw && i < TO; i++) begin
            v = base(1); v.mem_read = 1'b1;
            push(1'b1, op, f3, z, 1'b0, v, tag);
        end
        if (fw >= TO) begin
            m_to = 1'b1; plan_trap(5, tag); return;
        end
        v = base(1); v.mem_read = 1'b1; v.ir_we = 1'b1;
        push(1'b1, op, f3, z, 1'b1, v, tag);
        push(1'b1, op, f3, z, 1'b1, base(2), tag);
        if (k == K_BAD) begin
            m_ill = 1'b1; plan_trap(20, tag); return;
        end
        v = with_alu(base(3), k);
        if (k == K_BEQ || k == K_BNE) begin
            v.pc_we = 1'b1; v.instr_retired = 1'b1;
            v.pc_src = ((k == K_BEQ && z) || (k == K_BNE && !z)) ? 2'd1 : 2'd0;
            push(1'b1, op, f3, z, 1'b1, v, tag); return;
        end
        if (k == K_JAL || k == K_JALR) begin
            v.pc_we = 1'b1; v.reg_write = 1'b1; v.wb_sel = 2'd2; v.instr_retired = 1'b1;
            v.pc_src = (k == K_JALR) ? 2'd2 : 2'd1;
            push(1'b1, op, f3, z, 1'b1, v, tag); return;
        end
        push(1'b1, op, f3, z, 1'b1, v, tag);
        if (k == K_L || k == K_S) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                v = with_alu(base(4), k); v.mem_addr_sel = 1'b1;
                v.mem_read = (k == K_L); v.mem_write = (k == K_S);
                push(1'b1, op, f3, z, 1'b0, v, tag);
            end
            if (mw >= TO) begin
                m_to = 1'b1; plan_trap(5, tag); return;
            end
            v = with_alu(base(4), k); v.mem_addr_sel = 1'b1;
            if (k == K_L) begin
                v.mem_read = 1'b1; v.mdr_we = 1'b1;
                push(1'b1, op, f3, z, 1'b1, v, tag);
            end else begin
                v.mem_write = 1'b1; v.pc_we = 1'b1; v.instr_retired = 1'b1;
                push(1'b1, op, f3, z, 1'b1, v, tag); return;
            end
        end
        v = with_alu(base(5), k);
        v.reg_write = 1'b1; v.wb_sel = (k == K_L) ? 2'd1 : 2'd0;
        v.pc_we = 1'b1; v.instr_retired = 1'b1;
        push(1'b1, op, f3, z, 1'b1, v, tag);
    endtask

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Per-cycle comparison of every DUT output against the planned expectation
    always @(negedge CLK) begin
        if (chk_en) begin
            checks++;
            if (dut_v !== exp_cur) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", tag_cur, cyc, dut_v, exp_cur);
            end
        end
    end

    initial begin
        int    n0;
        int    cnt;
        outv_t lit;

        plan_reset("reset");
        n0 = plan.size();
        plan_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, "add");
        pin("cpi_add", plan.size() - n0, 4);
        lit = '0; lit.state = 3'd5; lit.reg_write = 1'b1; lit.pc_we = 1'b1; lit.instr_retired = 1'b1;
        pin("add_wb_vec", int'(plan[n0 + 3].exp), int'(lit));

        n0 = plan.size();
        plan_instr(K_L, 7'b0000011, 3'b010, 1'b0, 0, 0, "lw0");
        pin("cpi_lw", plan.size() - n0, 5);
        plan_instr(K_L, 7'b0000011, 3'b010, 1'b0, 0, 3, "lw3");
        n0 = plan.size();
        plan_instr(K_BEQ, 7'b1100011, 3'b000, 1'b1, 0, 0, "beq_z1");
        pin("cpi_beq", plan.size() - n0, 3);
        lit = '0; lit.state = 3'd3; lit.pc_we = 1'b1; lit.pc_src = 2'd1; lit.alu_op = 3'b100;
        lit.instr_retired = 1'b1;
        pin("beq_taken_vec", int'(plan[n0 + 2].exp), int'(lit));
        plan_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, "beq_z0");
        plan_instr(K_BNE, 7'b1100011, 3'b001, 1'b0, 0, 0, "bne_z0");
        plan_instr(K_BNE, 7'b1100011, 3'b001, 1'b1, 0, 0, "bne_z1");
        plan_instr(K_I, 7'b0010011, 3'b101, 1'b0, 1, 0, "addi");
        plan_instr(K_LUI, 7'b0110111, 3'b011, 1'b0, 0, 0, "lui");
        plan_instr(K_AUIPC, 7'b0010111, 3'b000, 1'b0, 2, 0, "auipc");
        plan_instr(K_JAL, 7'b1101111, 3'b111, 1'b1, 0, 0, "jal");
        plan_instr(K_JALR, 7'b1100111, 3'b000, 1'b0, 0, 0, "jalr");
        plan_instr(K_S, 7'b0100011, 3'b010, 1'b0, 0, 0, "sw0");
        plan_instr(K_S, 7'b0100011, 3'b010, 1'b0, 0, 2, "sw2");
        plan_instr(K_L, 7'b0000011, 3'b010, 1'b0, TO - 1, TO - 1, "lw_maxwait");

        plan_instr(K_BAD, 7'b0000000, 3'b000, 1'b0, 0, 0, "bad_op");
        plan_reset("reset2");
        plan_instr(K_BAD, 7'b0000011, 3'b000, 1'b0, 0, 0, "bad_lf3");
        plan_reset("reset3");
        plan_instr(K_BAD, 7'b1100011, 3'b010, 1'b0, 0, 0, "bad_bf3");
        plan_reset("reset4");

        n0 = plan.size();
        plan_instr(K_R, 7'b0110011, 3'b000, 1'b0, TO, 0, "fetch_to");
        cnt = 0;
        for (int i = n0; i < plan.size(); i++) cnt += int'(plan[i].exp.mem_read);
        pin("fetch_to_reads", cnt, 15);
        plan_reset("reset5");
        plan_instr(K_L, 7'b0000011, 3'b010, 1'b0, 0, TO, "mem_to");
        plan_reset("reset6");

        plan_instr(K_S, 7'b0100011, 3'b010, 1'b0, 0, 6, "sw_abort");
        for (int i = 0; i < 4; i++) void'(plan.pop_back());
        plan_reset("reset_mid_mem");
        plan_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, "add_after");

        foreach (plan[i]) begin
            @(posedge CLK);
            #1;
            RSTn = plan[i].rstn;
            opcode = plan[i].op;
            funct3 = plan[i].f3;
            zero = plan[i].z;
            mem_ready = plan[i].rdy;
            exp_cur = plan[i].exp;
            tag_cur = plan[i].tag;
            cyc = i;
            chk_en = 1'b1;
        end
        @(posedge CLK);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
